float_adder_param: RTL and testbench
====================================

Name: float_adder_param

Overview:
- Parametrised, handshaked successor to the fixed e4m3 adder: adds two sign/exponent/mantissa floats of configurable width.
- Multi-cycle FSM: align, add/subtract, iterative normalise, optional round-to-nearest-even.
- Handles zero, cancellation, overflow and underflow.
- Sits between operand producers and consumers via valid/ready on both sides.

Parameters:
- EXP_W, 4, exponent field width (>=2)
- MAN_W, 3, stored mantissa width, hidden bit excluded (>=1)
- BIAS, 7, exponent bias; documentation only, since the datapath never unbiases

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- a  in  1+EXP_W+MAN_W  operand A {sign, exp, man}
- b  in  1+EXP_W+MAN_W  operand B
- in_valid  in  1  operands present
- in_ready  out  1  block idle, can accept
- y  out  1+EXP_W+MAN_W  result, held stable while out_valid=1
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- overflow  out  1  result saturated; valid with out_valid
- underflow  out  1  result flushed to zero; valid with out_valid

Behaviour:
- Reset (reset=0, async): state=IDLE, y=0, out_valid=0, overflow=0, underflow=0, in_ready=1.
- Encoding:
  - exp==0 means zero; denormal inputs are flushed to zero.
  - All other exp values are normal, including all-ones (no Inf/NaN).
  - Max finite = {s, all-ones exp, all-ones man}.
- Operand capture: a, b latched on in_valid && in_ready. in_ready=1 only in IDLE.
- FSM states: IDLE, ALIGN, ADD, NORM, ROUND, DONE.
- IDLE -> ALIGN on accept.
- ALIGN (1 cycle):
  - Swap so the larger magnitude (exp, then man) is operand L.
  - Shift S's {1,man} right by the exponent difference into a MAN_W+4 bit datapath: carry, hidden, MAN_W, guard, round, sticky.
  - Any shifted-out 1 ORs into sticky.
  - A difference >= MAN_W+3 leaves only sticky.
  - A zero operand contributes a zero mantissa.
- ADD (1 cycle):
  - Same signs: add magnitudes. Different signs: L - S, never negative.
  - Result sign = sign of L.
  - Exact zero result: y=+0, go straight to DONE.
- NORM (1 cycle per step, at least 1):
  - Carry set: shift right 1, sticky-preserving, exp+1, then go to ROUND.
  - Else, while hidden bit is 0: shift left 1, exp-1.
  - exp reaching 0 before the hidden bit sets: underflow=1, y=+0, go to DONE.
  - Exits to ROUND when the hidden bit is 1.
- ROUND (1 cycle):
  - Apply rounding per the Optional Feature.
  - A mantissa carry-out renormalises: exp+1.
  - exp exceeding all-ones: saturate to max finite with sign, overflow=1.
- DONE:
  - out_valid=1, y and flags stable.
  - On out_ready: out_valid=0, go to IDLE. in_ready rises the next cycle; there is no same-cycle re-accept.
- Latency: ALIGN + ADD + NORM(k) + ROUND + 1 to out_valid. 5 cycles for a normalised sum (k=1). Max MAN_W+6.
- Simultaneous events: in_valid is ignored outside IDLE; out_ready is ignored outside DONE.
- Reset mid-operation aborts immediately to the reset state; no partial result is presented.

Optional Feature:
- Macro FLOAT_ADDER_PARAM_ROUND_EN.
- Defined: round-to-nearest, ties-to-even, using guard/round/sticky.
- Undefined: truncate. Guard/round/sticky are ignored and ROUND only performs the overflow check.
- Latency is identical in both builds.

Decomposition:
- Package float_adder_pkg:
  - state enum (IDLE..DONE)
  - localparams for field positions and widths (FW=1+EXP_W+MAN_W, DP_W=MAN_W+4)
  - max-finite exponent constant
  - function pack(sign, exp, man)
- One natural sub-module: float_align_shift, a combinational right shifter with sticky OR, parametrised on DP_W.

Test Plan (defaults, BIAS=7):
- 0x38+0x38 (1.0+1.0) -> y=0x40, overflow=0, underflow=0; out_valid 5 cycles after accept.
- 0x38+0xB8 (1.0+-1.0) -> y=0x00 (+0), skips NORM/ROUND.
- 0x38+0xB6 (1.0-0.875) -> y=0x20 (0.125); 4 NORM steps, out_valid 8 cycles after accept.
- 0x7F+0x7F -> y=0x7F, overflow=1; 0xFF+0xFF -> y=0xFF, overflow=1.
- Rounding:
  - 0x38+0x1C -> y=0x39 with FLOAT_ADDER_PARAM_ROUND_EN, 0x38 without.
  - 0x39+0x18 (tie) -> 0x3A with the macro, 0x39 without.
- Handshake: hold out_ready=0 for 3 cycles in DONE -> y and out_valid stable, in_ready=0. Assert reset=0 during NORM -> out_valid=0, in_ready=1 immediately; the next operation computes correctly.

Source files
------------

// File: rtl/float_adder_pkg.sv
// Shared state encoding, default geometry and packing helpers for the parametrised float adder.
package float_adder_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAlign,
    StAdd,
    StNorm,
    StRound,
    StDone
  } state_e;

  localparam int unsigned DefExpW = 4;
  localparam int unsigned DefManW = 3;
  localparam int unsigned DefBias = 7;
  localparam int unsigned DefFw   = 1 + DefExpW + DefManW;
  localparam int unsigned DefDpW  = DefManW + 4;

  // Low end of the aligned datapath: sticky, round, guard, then the mantissa LSB.
  localparam int unsigned StickyPos = 0;
  localparam int unsigned RoundPos  = 1;
  localparam int unsigned GuardPos  = 2;
  localparam int unsigned ManLsbPos = 3;

  function automatic int unsigned all_ones(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  localparam int unsigned DefExpMax = all_ones(DefExpW);

  function automatic logic [63:0] pack(input logic        sign,
                                       input logic [31:0] exp,
                                       input logic [31:0] man,
                                       input int unsigned exp_w,
                                       input int unsigned man_w);
    return ({63'd0, sign} << (exp_w + man_w)) | ({32'd0, exp} << man_w) | {32'd0, man};
  endfunction

endpackage

// File: rtl/float_adder_param_align_shift.sv
// Combinational alignment shifter: right shift with every bit pushed below bit 0 ORed into
// the sticky bit.
module float_align_shift
  import float_adder_pkg::*;
#(
  parameter int unsigned DP_W = DefDpW,
  parameter int unsigned SH_W = DefExpW
) (
  input  logic [DP_W-1:0] data_i,
  input  logic [SH_W-1:0] shamt_i,
  output logic [DP_W-1:0] data_o
);

  logic [DP_W-1:0] shifted;
  logic            lost;

  always_comb begin
    lost = 1'b0;
    for (int i = 0; i < DP_W; i++) begin
      if (i < int'(shamt_i)) lost = lost | data_i[i];
    end
    shifted = data_i >> shamt_i;
    data_o  = {shifted[DP_W-1:1], shifted[0] | lost};
  end

endmodule

// File: rtl/float_adder_param.sv
// Handshaked multi-cycle float adder (align, add, iterative normalise, round).
// Define FLOAT_ADDER_PARAM_ROUND_EN for round-to-nearest-even; otherwise the result is truncated.
module float_adder_param
  import float_adder_pkg::*;
#(
  parameter int unsigned EXP_W = DefExpW,
  parameter int unsigned MAN_W = DefManW,
  parameter int unsigned BIAS  = DefBias
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [EXP_W+MAN_W:0] y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int unsigned    Fw      = 1 + EXP_W + MAN_W;
  localparam int unsigned    DpW     = MAN_W + 4;
  localparam int unsigned    ExpMaxI = all_ones(EXP_W);
  localparam logic [EXP_W:0] ExpMax  = ExpMaxI[EXP_W:0];
  localparam logic [EXP_W:0] ExpOne  = 1;

  // The datapath never unbiases, so the bias has no hardware.
  logic unused_bias;
  assign unused_bias = ^BIAS;

  state_e         state_q, state_d;
  logic [Fw-1:0]  a_q, a_d, b_q, b_d, y_q, y_d;
  logic           sign_q, sign_d, sub_q, sub_d, ovf_q, ovf_d, unf_q, unf_d;
  logic [EXP_W:0] exp_q, exp_d;
  logic [DpW:0]   man_q, man_d;
  logic [DpW-1:0] sml_q, sml_d;

  logic             a_zero, b_zero, swap, l_zero, s_zero;
  logic [Fw-1:0]    l_op, s_op;
  logic [EXP_W-1:0] l_exp, s_exp, exp_diff;
  logic [DpW-1:0]   s_unaligned, s_aligned;

  always_comb begin
    a_zero = a_q[Fw-2:MAN_W] == '0;
    b_zero = b_q[Fw-2:MAN_W] == '0;
    // Zero and denormal operands compare as magnitude 0.
    swap   = (b_zero ? '0 : b_q[Fw-2:0]) > (a_zero ? '0 : a_q[Fw-2:0]);
    l_op   = swap ? b_q : a_q;
    s_op   = swap ? a_q : b_q;
    l_zero = swap ? b_zero : a_zero;
    s_zero = swap ? a_zero : b_zero;
    l_exp  = l_op[Fw-2:MAN_W];
    s_exp  = s_op[Fw-2:MAN_W];
    exp_diff    = l_exp - s_exp;
    s_unaligned = s_zero ? '0 : {1'b1, s_op[MAN_W-1:0], 3'b000};
  end

  float_align_shift #(
    .DP_W (DpW),
    .SH_W (EXP_W)
  ) u_align_shift (
    .data_i  (s_unaligned),
    .shamt_i (exp_diff),
    .data_o  (s_aligned)
  );

  logic [DpW:0]     sum;
  logic             round_up;
  logic [MAN_W+1:0] rnd;
  logic [EXP_W:0]   exp_rnd;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    y_d     = y_q;
    sign_d  = sign_q;
    sub_d   = sub_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    exp_d   = exp_q;
    man_d   = man_q;
    sml_d   = sml_q;

    sum = sub_q ? man_q - {1'b0, sml_q} : man_q + {1'b0, sml_q};
`ifdef FLOAT_ADDER_PARAM_ROUND_EN
    round_up = man_q[GuardPos] & (man_q[RoundPos] | man_q[StickyPos] | man_q[ManLsbPos]);
`else
    round_up = 1'b0;
`endif
    rnd     = {1'b0, man_q[DpW-1:ManLsbPos]} + {{(MAN_W+1){1'b0}}, round_up};
    exp_rnd = exp_q + {{EXP_W{1'b0}}, rnd[MAN_W+1]};

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          state_d = StAlign;
        end
      end
      StAlign: begin
        sign_d  = l_op[Fw-1];
        sub_d   = a_q[Fw-1] ^ b_q[Fw-1];
        exp_d   = {1'b0, l_exp};
        man_d   = l_zero ? '0 : {2'b01, l_op[MAN_W-1:0], 3'b000};
        sml_d   = s_aligned;
        state_d = StAdd;
      end
      StAdd: begin
        if (sum == '0) begin
          y_d     = '0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = StDone;
        end else begin
          man_d   = sum;
          state_d = StNorm;
        end
      end
      StNorm: begin
        if (man_q[DpW]) begin
          man_d   = {1'b0, man_q[DpW:2], |man_q[1:0]};
          exp_d   = exp_q + ExpOne;
          state_d = StRound;
        end else if (man_q[DpW-1]) begin
          state_d = StRound;
        end else if (exp_q[EXP_W:1] == '0) begin
          // Another left shift would take the exponent to the zero encoding.
          y_d     = '0;
          ovf_d   = 1'b0;
          unf_d   = 1'b1;
          state_d = StDone;
        end else begin
          man_d = man_q << 1;
          exp_d = exp_q - ExpOne;
        end
      end
      StRound: begin
        if (exp_rnd > ExpMax) begin
          y_d   = Fw'(pack(sign_q, ExpMaxI, all_ones(MAN_W), EXP_W, MAN_W));
          ovf_d = 1'b1;
        end else begin
          y_d   = Fw'(pack(sign_q, 32'(exp_rnd[EXP_W-1:0]), 32'(rnd[MAN_W-1:0]), EXP_W, MAN_W));
          ovf_d = 1'b0;
        end
        unf_d   = 1'b0;
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      sign_q  <= 1'b0;
      sub_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      exp_q   <= '0;
      man_q   <= '0;
      sml_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
      sign_q  <= sign_d;
      sub_q   <= sub_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      exp_q   <= exp_d;
      man_q   <= man_d;
      sml_q   <= sml_d;
    end
  end

  assign in_ready  = state_q == StIdle;
  assign out_valid = state_q == StDone;
  assign y         = y_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_float_adder_param.sv
// Directed self-checking bench for float_adder_param at its default e4m3 geometry.
module tb_float_adder_param;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] y;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       overflow;
  logic       underflow;

  int total = 0;
  int bad   = 0;

`ifdef FLOAT_ADDER_PARAM_ROUND_EN
  localparam bit RoundEn = 1'b1;
`else
  localparam bit RoundEn = 1'b0;
`endif

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
    logic       ovf;
    logic       unf;
    int         lat;
  } vec_t;

  float_adder_param u_dut (
    .clock     (clock),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clock = ~clock;

  // Latency counts the accepting edge as 1 and each later edge up to out_valid.
  task automatic run_op(input logic [7:0] op_a, input logic [7:0] op_b, output logic [7:0] ry,
                        output logic rovf, output logic runf, output int lat);
    @(negedge clock);
    a = op_a;
    b = op_b;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
    end
    ry   = y;
    rovf = overflow;
    runf = underflow;
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3 reset = 1'b0;
    #1;
    total++;
    if ({y, out_valid, overflow, underflow, in_ready} !== {8'h00, 4'b0001}) begin
      bad++;
      $display("FAIL reset_state: got y=%h ov=%b of=%b uf=%b ir=%b, want y=00 ov=0 of=0 uf=0 ir=1",
               y, out_valid, overflow, underflow, in_ready);
    end
    a = 8'h38;
    b = 8'h38;
    in_valid = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL reset_held: got ov=%b ir=%b, want ov=0 ir=1", out_valid, in_ready);
    end
    @(negedge clock);
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1;
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL reset_release: got ov=%b ir=%b, want ov=0 ir=1", out_valid, in_ready);
    end
  endtask

  task automatic test_arith();
    vec_t v[6];
    logic [7:0] ry;
    logic rovf, runf;
    int lat;
    v[0] = '{"one_plus_one",  8'h38, 8'h38, 8'h40, 1'b0, 1'b0, 5};
    v[1] = '{"one_minus_7_8", 8'h38, 8'hB6, 8'h20, 1'b0, 1'b0, 8};
    v[2] = '{"swapped_order", 8'hB6, 8'h38, 8'h20, 1'b0, 1'b0, 8};
    v[3] = '{"two_minus_one", 8'h40, 8'hB8, 8'h38, 1'b0, 1'b0, 6};
    v[4] = '{"far_apart",     8'h78, 8'h08, 8'h78, 1'b0, 1'b0, 5};
    v[5] = '{"denorm_flush",  8'h38, 8'h05, 8'h38, 1'b0, 1'b0, 5};
    foreach (v[i]) begin
      run_op(v[i].a, v[i].b, ry, rovf, runf, lat);
      total++;
      if ({ry, rovf, runf} !== {v[i].y, v[i].ovf, v[i].unf}) begin
        bad++;
        $display("FAIL %s: got y=%h of=%b uf=%b, want y=%h of=%b uf=%b", v[i].name, ry, rovf,
                 runf, v[i].y, v[i].ovf, v[i].unf);
      end
      total++;
      if (lat !== v[i].lat) begin
        bad++;
        $display("FAIL %s_latency: got %0d, want %0d", v[i].name, lat, v[i].lat);
      end
    end
  endtask

  task automatic test_limits();
    vec_t v[6];
    logic [7:0] ry;
    logic rovf, runf;
    int lat;
    v[0] = '{"cancel",       8'h38, 8'hB8, 8'h00, 1'b0, 1'b0, 3};
    v[1] = '{"neg_zeros",    8'h80, 8'h80, 8'h00, 1'b0, 1'b0, 3};
    v[2] = '{"denorm_pair",  8'h05, 8'h83, 8'h00, 1'b0, 1'b0, 3};
    v[3] = '{"overflow_pos", 8'h7F, 8'h7F, 8'h7F, 1'b1, 1'b0, 5};
    v[4] = '{"overflow_neg", 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 5};
    v[5] = '{"underflow",    8'h09, 8'h88, 8'h00, 1'b0, 1'b1, 4};
    foreach (v[i]) begin
      run_op(v[i].a, v[i].b, ry, rovf, runf, lat);
      total++;
      if ({ry, rovf, runf} !== {v[i].y, v[i].ovf, v[i].unf}) begin
        bad++;
        $display("FAIL %s: got y=%h of=%b uf=%b, want y=%h of=%b uf=%b", v[i].name, ry, rovf,
                 runf, v[i].y, v[i].ovf, v[i].unf);
      end
      total++;
      if (lat !== v[i].lat) begin
        bad++;
        $display("FAIL %s_latency: got %0d, want %0d", v[i].name, lat, v[i].lat);
      end
    end
  endtask

  task automatic test_round();
    vec_t v[5];
    logic [7:0] ry;
    logic rovf, runf;
    int lat;
    v[0] = '{"round_up",      8'h38, 8'h1C, RoundEn ? 8'h39 : 8'h38, 1'b0, 1'b0, 5};
    v[1] = '{"tie_to_even",   8'h39, 8'h18, RoundEn ? 8'h3A : 8'h39, 1'b0, 1'b0, 5};
    v[2] = '{"tie_stays",     8'h38, 8'h18, 8'h38, 1'b0, 1'b0, 5};
    v[3] = '{"round_carry",   8'h3F, 8'h1C, RoundEn ? 8'h40 : 8'h3F, 1'b0, 1'b0, 5};
    v[4] = '{"round_to_ovf",  8'h7F, 8'h5C, 8'h7F, RoundEn, 1'b0, 5};
    foreach (v[i]) begin
      run_op(v[i].a, v[i].b, ry, rovf, runf, lat);
      total++;
      if ({ry, rovf, runf} !== {v[i].y, v[i].ovf, v[i].unf}) begin
        bad++;
        $display("FAIL %s: got y=%h of=%b uf=%b, want y=%h of=%b uf=%b", v[i].name, ry, rovf,
                 runf, v[i].y, v[i].ovf, v[i].unf);
      end
      total++;
      if (lat !== v[i].lat) begin
        bad++;
        $display("FAIL %s_latency: got %0d, want %0d", v[i].name, lat, v[i].lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clock);
    a = 8'h38;
    b = 8'h38;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
    end
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL hold_reach_done: got ov=%b after %0d cycles, want ov=1", out_valid, lat);
    end
    // New operands offered while DONE must be ignored until the block is idle again.
    a = 8'h7F;
    b = 8'h7F;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      total++;
      if ({out_valid, in_ready, y, overflow} !== {1'b1, 1'b0, 8'h40, 1'b0}) begin
        bad++;
        $display("FAIL hold_cycle%0d: got ov=%b ir=%b y=%h of=%b, want ov=1 ir=0 y=40 of=0", i,
                 out_valid, in_ready, y, overflow);
      end
    end
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL release_no_reaccept: got ov=%b ir=%b, want ov=0 ir=1", out_valid, in_ready);
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL next_accept: got ir=%b, want ir=0", in_ready);
    end
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
    end
    total++;
    if ({y, overflow, underflow, lat} !== {8'h7F, 1'b1, 1'b0, 32'd5}) begin
      bad++;
      $display("FAIL next_result: got y=%h of=%b uf=%b lat=%0d, want y=7f of=1 uf=0 lat=5", y,
               overflow, underflow, lat);
    end
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] ry;
    logic rovf, runf;
    int lat;
    @(negedge clock);
    a = 8'h38;
    b = 8'hB6;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    total++;
    if ({out_valid, in_ready, y, overflow, underflow} !== {1'b0, 1'b1, 8'h00, 2'b00}) begin
      bad++;
      $display("FAIL reset_mid_abort: got ov=%b ir=%b y=%h of=%b uf=%b, want ov=0 ir=1 y=00",
               out_valid, in_ready, y, overflow, underflow);
    end
    @(negedge clock);
    reset = 1'b1;
    run_op(8'h38, 8'h38, ry, rovf, runf, lat);
    total++;
    if ({ry, rovf, runf, lat} !== {8'h40, 1'b0, 1'b0, 32'd5}) begin
      bad++;
      $display("FAIL reset_mid_recover: got y=%h of=%b uf=%b lat=%0d, want y=40 of=0 uf=0 lat=5",
               ry, rovf, runf, lat);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_limits();
    test_round();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
